// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS-style controller, ALU core and datapath:
// opcodes, funct codes, ALU operation codes, mux selects and FSM state codes.
package mc_controller_pkg;

  // Instruction opcodes, taken from instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct codes, taken from instruction bits [5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes understood by the ALU core
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM state codes; 12..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle. There is no valid/ready handshake here: the
// instruction fields and zero flag are level inputs sampled every cycle, and every
// control output is a level signal valid for the whole cycle of the current state.
interface mc_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [2:0] alu_ctrl;
  logic       illegal;
  logic [3:0] state;

  // Controller side: consumes instruction fields, drives the datapath controls
  modport master (
    input  opcode, funct, zero,
    output pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, pc_source, alu_ctrl, illegal, state
  );

  // Datapath side: supplies instruction fields, obeys the controls
  modport slave (
    output opcode, funct, zero,
    input  pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, pc_source, alu_ctrl, illegal, state
  );
endinterface

// File: rtl/mc_controller_alu_ctrl_dec.sv
// Combinational funct -> ALU operation decode for R-type instructions.
// Unsupported funct codes fall back to add and deassert o_funct_ok.
module alu_ctrl_dec
  import mc_controller_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctrl,
  output logic       o_funct_ok
);

  // Map funct to ALU operation; default is add with the funct flagged bad
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_funct_ok = 1'b1;
    case (i_funct)
      FN_ADD:  o_alu_ctrl = ALU_ADD;
      FN_SUB:  o_alu_ctrl = ALU_SUB;
      FN_AND:  o_alu_ctrl = ALU_AND;
      FN_OR:   o_alu_ctrl = ALU_OR;
      FN_SLT:  o_alu_ctrl = ALU_SLT;
      default: o_funct_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller: Moore FSM sequencing fetch, decode, execute, memory and
// writeback. Only pc_en looks at the ALU zero flag; everything else decodes from
// the state register plus the opcode/funct fields.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  mc_controller_if.master  bus
);

  state_t     r_state;
  state_t     w_next;
  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_mem_to_reg;
  logic       w_reg_dst;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_pc_source;
  logic [2:0] w_alu_ctrl;
  logic       w_illegal;
  logic [2:0] w_fn_alu_ctrl;
  logic       w_fn_ok;

  alu_ctrl_dec u_alu_ctrl_dec (
    .i_funct    (bus.funct),
    .o_alu_ctrl (w_fn_alu_ctrl),
    .o_funct_ok (w_fn_ok)
  );

  // State register; reset forces FETCH from any state, even mid-instruction
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state and control decode; everything defaults low, ALU defaults to add
  always_comb begin
    w_next          = S_FETCH;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = SRCB_REGB;
    w_pc_source     = PCSRC_ALU;
    w_alu_ctrl      = ALU_ADD;
    w_illegal       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_ir_write  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        w_pc_write  = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_b = SRCB_IMMSH;
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default:      w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        w_next     = S_MEMWB;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
      end
      S_EXEC: begin
        // Bad funct aborts straight to FETCH so no register is written
        w_alu_src_a = 1'b1;
        w_alu_ctrl  = w_fn_alu_ctrl;
        w_illegal   = ~w_fn_ok;
        w_next      = w_fn_ok ? S_ALUWB : S_FETCH;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_ctrl      = ALU_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
      end
      default: begin
        // Unused codes: every output low, including the ALU operation
        w_alu_ctrl = 3'b000;
      end
    endcase
  end

  // Drive the bundle; pc_en is the only output that depends on the zero flag
  always_comb begin
    bus.pc_en      = w_pc_write | (w_pc_write_cond & bus.zero);
    bus.iord       = w_iord;
    bus.mem_read   = w_mem_read;
    bus.mem_write  = w_mem_write;
    bus.ir_write   = w_ir_write;
    bus.mem_to_reg = w_mem_to_reg;
    bus.reg_dst    = w_reg_dst;
    bus.reg_write  = w_reg_write;
    bus.alu_src_a  = w_alu_src_a;
    bus.alu_src_b  = w_alu_src_b;
    bus.pc_source  = w_pc_source;
    bus.alu_ctrl   = w_alu_ctrl;
    bus.illegal    = w_illegal;
    bus.state      = r_state;
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: expected per-cycle control vectors are pushed when an
// instruction is driven and popped/compared each cycle the DUT holds a state.
module tb_mc_controller;

  localparam int VW = 21;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [VW-1:0] exp_q[$];

  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected vector for a state from the control table:
  // {state, pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
  //  reg_write, alu_src_a, alu_src_b, pc_source, alu_ctrl, illegal}
  function automatic logic [VW-1:0] exp_vec(input logic [3:0] st, input logic [5:0] op,
                                            input logic [5:0] fn, input logic z);
    logic pcw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    {pcw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
    sb = 2'b00; ps = 2'b00; alu = 3'b010;
    case (st)
      4'd0: begin mr = 1; irw = 1; sb = 2'b01; pcw = 1; end
      4'd1: begin
        sb = 2'b11;
        ill = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000});
      end
      4'd2, 4'd10: begin sa = 1; sb = 2'b10; end
      4'd3: begin mr = 1; iord = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mw = 1; iord = 1; end
      4'd6: begin
        sa = 1;
        case (fn)
          6'b100000: alu = 3'b010;
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default:   ill = 1;
        endcase
      end
      4'd7: begin rw = 1; rd = 1; end
      4'd8: begin sa = 1; alu = 3'b110; pwc = 1; ps = 2'b01; end
      4'd9: begin pcw = 1; ps = 2'b10; end
      4'd11: rw = 1;
      default: alu = 3'b000;
    endcase
    return {st, pcw | (pwc & z), iord, mr, mw, irw, m2r, rd, rw, sa, sb, ps, alu, ill};
  endfunction

  // Expected state walk for one instruction, starting at FETCH
  task automatic exp_seq(input logic [5:0] op, input logic [5:0] fn,
                         output int n, output logic [3:0] seq [0:5]);
    for (int i = 0; i < 6; i++) seq[i] = 4'd0;
    seq[1] = 4'd1;
    n = 2;
    case (op)
      6'b100011: begin seq[2] = 4'd2; seq[3] = 4'd3; seq[4] = 4'd4; n = 5; end
      6'b101011: begin seq[2] = 4'd2; seq[3] = 4'd5; n = 4; end
      6'b000000: begin
        seq[2] = 4'd6;
        n = 3;
        if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
          seq[3] = 4'd7; n = 4;
        end
      end
      6'b000100: begin seq[2] = 4'd8; n = 3; end
      6'b000010: begin seq[2] = 4'd9; n = 3; end
      6'b001000: begin seq[2] = 4'd10; seq[3] = 4'd11; n = 4; end
      default: n = 2;
    endcase
  endtask

  function automatic logic [VW-1:0] obs_vec();
    return {bus.state, bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.pc_source, bus.alu_ctrl, bus.illegal};
  endfunction

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard pop/compare for the current cycle
  task automatic cmp_cycle(input string tag);
    logic [VW-1:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, {11'd0, obs_vec()}, {11'd0, e});
    end
  endtask

  // Driver: present an instruction in FETCH and walk it; stop_at < 0 runs it to
  // completion (ending back in FETCH), otherwise stops while holding that step
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int stop_at);
    int n;
    logic [3:0] seq [0:5];
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    exp_seq(op, fn, n, seq);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_vec(seq[i], op, fn, z));
      cmp_cycle($sformatf("%s_c%0d_s%0d", name, i, seq[i]));
      if (i == stop_at) return;
      adv();
    end
  endtask

  logic [5:0] op_tab [0:6];
  logic [5:0] fn_tab [0:4];

  initial begin
    logic [5:0] op, fn;
    n_tests = 0;
    n_fail  = 0;
    op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    bus.opcode = 6'b000000;
    bus.funct  = 6'b000000;
    bus.zero   = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // After reset: FETCH with no writes
    check_val("reset_state", {28'd0, bus.state}, 32'd0);
    check_val("reset_no_write", {30'd0, bus.reg_write, bus.mem_write}, 32'd0);

    run_instr("lw",       6'b100011, 6'b000000, 1'b0, -1);
    run_instr("r_slt",    6'b000000, 6'b101010, 1'b0, -1);
    run_instr("r_sub",    6'b000000, 6'b100010, 1'b1, -1);
    run_instr("r_and",    6'b000000, 6'b100100, 1'b0, -1);
    run_instr("r_or",     6'b000000, 6'b100101, 1'b0, -1);
    run_instr("beq_z1",   6'b000100, 6'b000000, 1'b1, -1);
    run_instr("beq_z0",   6'b000100, 6'b000000, 1'b0, -1);
    run_instr("j",        6'b000010, 6'b000000, 1'b1, -1);
    run_instr("addi",     6'b001000, 6'b000000, 1'b0, -1);
    run_instr("sw",       6'b101011, 6'b000000, 1'b0, -1);
    run_instr("ill_op",   6'b111111, 6'b000000, 1'b0, -1);
    run_instr("ill_fn",   6'b000000, 6'b000000, 1'b0, -1);

    // Reset while in MEMWR (step 3 of sw)
    run_instr("sw_rst", 6'b101011, 6'b000000, 1'b0, 3);
    reset = 1'b1;
    adv();
    reset = 1'b0;
    check_val("rst_memwr_state", {28'd0, bus.state}, 32'd0);
    check_val("rst_memwr_mem_write", {31'd0, bus.mem_write}, 32'd0);

    // Reset while in MEMRD (step 3 of lw)
    run_instr("lw_rst", 6'b100011, 6'b000000, 1'b0, 3);
    reset = 1'b1;
    adv();
    reset = 1'b0;
    check_val("rst_memrd_state", {28'd0, bus.state}, 32'd0);

    // Randomised instruction stream
    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(0, 7) == 7) ? 6'($urandom_range(0, 63))
                                       : op_tab[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 5) == 5) ? 6'($urandom_range(0, 63))
                                       : fn_tab[$urandom_range(0, 4)];
      run_instr($sformatf("rnd%0d", k), op, fn, 1'($urandom_range(0, 1)), -1);
    end

    check_val("final_state", {28'd0, bus.state}, 32'd0);
    check_val("q_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
